// File: rtl/brg_slave_xcel_gcd_array.sv
// Multi-channel GCD accelerator behind a manycore endpoint slave port.
// Each channel owns OPA/OPB/CTRL/RESULT registers and runs a subtractive GCD engine.
module brg_slave_xcel_gcd_array #(
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 32,
    parameter int num_chan_p      = 4,
    parameter bit blocking_read_p = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      in_v_i,
    input  logic [addr_width_p-1:0]   in_addr_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic [data_width_p/8-1:0] in_mask_i,
    input  logic                      in_we_i,
    output logic                      in_yumi_o,
    output logic                      returning_v_o,
    output logic [data_width_p-1:0]   returning_data_o,
    output logic [num_chan_p-1:0]     done_o
);

    // state   | meaning
    // IDLE    | waiting for a go on CTRL
    // CALC    | one subtract/swap step per cycle on a/b
    // DONE    | result valid; cleared by an accepted RESULT read
    localparam int chan_idx_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int mask_w_lp     = data_width_p / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q  [num_chan_p];
    state_e                  state_d  [num_chan_p];
    logic [data_width_p-1:0] opa_q    [num_chan_p];
    logic [data_width_p-1:0] opa_d    [num_chan_p];
    logic [data_width_p-1:0] opb_q    [num_chan_p];
    logic [data_width_p-1:0] opb_d    [num_chan_p];
    logic [data_width_p-1:0] a_q      [num_chan_p];
    logic [data_width_p-1:0] a_d      [num_chan_p];
    logic [data_width_p-1:0] b_q      [num_chan_p];
    logic [data_width_p-1:0] b_d      [num_chan_p];
    logic [data_width_p-1:0] result_q [num_chan_p];
    logic [data_width_p-1:0] result_d [num_chan_p];

    logic                     ret_v_q, ret_v_d;
    logic [data_width_p-1:0]  ret_data_q, ret_data_d;
    logic [data_width_p-1:0]  rd_data;
    logic [1:0]               reg_sel;
    logic [chan_idx_w_lp-1:0] chan_sel, chan_idx;
    logic                     in_range, sel_calc, stall, yumi;
    logic [num_chan_p-1:0]    sel_oh;

    assign reg_sel  = in_addr_i[1:0];
    assign chan_sel = in_addr_i[2 +: chan_idx_w_lp];
    assign in_range = ({1'b0, chan_sel} < (chan_idx_w_lp+1)'(num_chan_p));
    assign chan_idx = in_range ? chan_sel : '0;
    assign sel_calc = in_range && (state_q[chan_idx] == ST_CALC);
    assign stall    = blocking_read_p && !in_we_i && (reg_sel == 2'd3) && sel_calc;
    // Gating with reset keeps the endpoint from seeing an accept while the array is held.
    assign yumi     = in_v_i && !stall && reset_n_i;

    assign in_yumi_o        = yumi;
    assign returning_v_o    = ret_v_q;
    assign returning_data_o = ret_data_q;

    always_comb begin
        sel_oh = '0;
        if (yumi && in_range) sel_oh[chan_idx] = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            case (reg_sel)
                2'd0: rd_data = opa_q[chan_idx];
                2'd1: rd_data = opb_q[chan_idx];
                2'd2: begin
                    rd_data[0] = (state_q[chan_idx] == ST_CALC);
                    rd_data[1] = (state_q[chan_idx] == ST_DONE);
                end
                default: rd_data = result_q[chan_idx];
            endcase
        end
    end

    assign ret_v_d    = yumi;
    assign ret_data_d = (yumi && !in_we_i) ? rd_data : '0;

    always_comb begin
        for (int i = 0; i < num_chan_p; i++) begin
            state_d[i]  = state_q[i];
            opa_d[i]    = opa_q[i];
            opb_d[i]    = opb_q[i];
            a_d[i]      = a_q[i];
            b_d[i]      = b_q[i];
            result_d[i] = result_q[i];
            done_o[i]   = (state_q[i] == ST_DONE);
            case (state_q[i])
                ST_IDLE, ST_DONE: begin
                    if (sel_oh[i] && in_we_i) begin
                        for (int k = 0; k < mask_w_lp; k++) begin
                            if (in_mask_i[k] && reg_sel == 2'd0) opa_d[i][8*k +: 8] = in_data_i[8*k +: 8];
                            if (in_mask_i[k] && reg_sel == 2'd1) opb_d[i][8*k +: 8] = in_data_i[8*k +: 8];
                        end
                        if (reg_sel == 2'd2 && in_mask_i[0]) begin
                            a_d[i]     = opa_q[i];
                            b_d[i]     = opb_q[i];
                            state_d[i] = ST_CALC;
                        end
                    end else if (sel_oh[i] && reg_sel == 2'd3 && state_q[i] == ST_DONE) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (b_q[i] == '0) begin
                        result_d[i] = a_q[i];
                        state_d[i]  = ST_DONE;
                    end else if (a_q[i] < b_q[i]) begin
                        a_d[i] = b_q[i];
                        b_d[i] = a_q[i];
                    end else begin
                        a_d[i] = a_q[i] - b_q[i];
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ret_v_q    <= 1'b0;
            ret_data_q <= '0;
            for (int i = 0; i < num_chan_p; i++) begin
                state_q[i]  <= ST_IDLE;
                opa_q[i]    <= '0;
                opb_q[i]    <= '0;
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                result_q[i] <= '0;
            end
        end else begin
            ret_v_q    <= ret_v_d;
            ret_data_q <= ret_data_d;
            for (int i = 0; i < num_chan_p; i++) begin
                state_q[i]  <= state_d[i];
                opa_q[i]    <= opa_d[i];
                opb_q[i]    <= opb_d[i];
                a_q[i]      <= a_d[i];
                b_q[i]      <= b_d[i];
                result_q[i] <= result_d[i];
            end
        end
    end

endmodule

// File: tb/tb_brg_slave_xcel_gcd_array.sv
// Bench for the GCD array: a 4-channel blocking instance and a 3-channel non-blocking one.
// Responses are matched against a per-instance queue of expected read data.
module tb_brg_slave_xcel_gcd_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic        in_we;
    logic        v0, v1, yumi0, yumi1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic [3:0]  done0;
    logic [2:0]  done1;
    logic        acc0, acc1;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    brg_slave_xcel_gcd_array #(.num_chan_p(4), .blocking_read_p(1'b1)) u_dut4 (
        .clk_i(clk), .reset_n_i(rst_n), .in_v_i(v0), .in_addr_i(in_addr),
        .in_data_i(in_data), .in_mask_i(in_mask), .in_we_i(in_we), .in_yumi_o(yumi0),
        .returning_v_o(rv0), .returning_data_o(rd0), .done_o(done0));

    brg_slave_xcel_gcd_array #(.num_chan_p(3), .blocking_read_p(1'b0)) u_dut3 (
        .clk_i(clk), .reset_n_i(rst_n), .in_v_i(v1), .in_addr_i(in_addr),
        .in_data_i(in_data), .in_mask_i(in_mask), .in_we_i(in_we), .in_yumi_o(yumi1),
        .returning_v_o(rv1), .returning_data_o(rd1), .done_o(done1));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0 <= 1'b0;
            acc1 <= 1'b0;
        end else begin
            acc0 <= v0 & yumi0;
            acc1 <= v1 & yumi1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            vectors++;
            if (rv0 !== acc0) begin miscompares++; $display("FAIL ret_v dut4 got %b want %b", rv0, acc0); end
            if (rv0 === 1'b1) begin
                if (sb0.size() == 0) begin miscompares++; $display("FAIL dut4 unexpected response data %h", rd0); end
                else begin
                    e = sb0.pop_front();
                    vectors++;
                    if (rd0 !== e) begin miscompares++; $display("FAIL dut4 ret_data got %h want %h", rd0, e); end
                end
            end
            vectors++;
            if (rv1 !== acc1) begin miscompares++; $display("FAIL ret_v dut3 got %b want %b", rv1, acc1); end
            if (rv1 === 1'b1) begin
                if (sb1.size() == 0) begin miscompares++; $display("FAIL dut3 unexpected response data %h", rd1); end
                else begin
                    e = sb1.pop_front();
                    vectors++;
                    if (rd1 !== e) begin miscompares++; $display("FAIL dut3 ret_data got %h want %h", rd1, e); end
                end
            end
        end
    end

    // Issued just after a negedge; returns on the negedge where the response is visible.
    task automatic req(input bit d, input bit we, input int ch, input int r, input logic [31:0] data,
                       input logic [3:0] mask, input logic [31:0] exp, output int n);
        in_we   = we;
        in_addr = 32'((ch << 2) | r);
        in_data = data;
        in_mask = mask;
        if (d) v1 = 1'b1; else v0 = 1'b1;
        #1;
        n = 0;
        while (!(d ? yumi1 : yumi0) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("FAIL yumi timeout ch %0d reg %0d got stalled want accepted", ch, r);
            v0 = 1'b0; v1 = 1'b0;
            return;
        end
        if (d) sb1.push_back(exp); else sb0.push_back(exp);
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic wr(input bit d, input int ch, input int r, input logic [31:0] data, input logic [3:0] mask);
        int n;
        req(d, 1'b1, ch, r, data, mask, 32'h0, n);
    endtask

    task automatic rd(input bit d, input int ch, input int r, input logic [31:0] exp);
        int n;
        req(d, 1'b0, ch, r, 32'h0, 4'hF, exp, n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v0 = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (rv0 !== 1'b0 || rd0 !== 32'h0 || done0 !== 4'h0) begin
            miscompares++; $display("FAIL reset_outputs got v%b d%h done%h want 0", rv0, rd0, done0);
        end
        vectors++;
        if (yumi0 !== 1'b0) begin miscompares++; $display("FAIL reset_yumi got %b want 0", yumi0); end
        v0 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        wr(0, 0, 0, 32'd15, 4'hF);
        wr(0, 0, 1, 32'd5, 4'hF);
        wr(0, 0, 2, 32'h1, 4'h1);
        n = 0;
        while (done0[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (n != 5) begin miscompares++; $display("FAIL calc_cycles got %0d want 5", n); end
        rd(0, 0, 2, 32'h2);
        rd(0, 0, 3, 32'd5);
        vectors++;
        if (done0[0] !== 1'b0) begin miscompares++; $display("FAIL done_clear got %b want 0", done0[0]); end
    endtask

    task automatic test_blocking;
        int n;
        wr(0, 0, 0, 32'd48, 4'hF);
        wr(0, 0, 1, 32'd18, 4'hF);
        wr(0, 0, 2, 32'h1, 4'h1);
        req(0, 1'b0, 0, 3, 32'h0, 4'hF, 32'd6, n);
        vectors++;
        if (n != 9) begin miscompares++; $display("FAIL blocking_stall got %0d want 9", n); end
        vectors++;
        if (done0[0] !== 1'b0) begin miscompares++; $display("FAIL blocking_done got %b want 0", done0[0]); end
    endtask

    task automatic test_byte_mask;
        int n;
        wr(0, 2, 0, 32'hFFFF_FFFF, 4'hF);
        wr(0, 2, 0, 32'h0000_0012, 4'h1);
        rd(0, 2, 0, 32'hFFFF_FF12);
        wr(0, 2, 0, 32'h00AB_0000, 4'h4);
        rd(0, 2, 0, 32'hFFAB_FF12);
        wr(0, 2, 2, 32'h1, 4'h0);
        rd(0, 2, 2, 32'h0);
        wr(0, 2, 0, 32'd12, 4'hF);
        wr(0, 2, 1, 32'd4, 4'hF);
        wr(0, 2, 2, 32'h1, 4'h1);
        wr(0, 2, 0, 32'h77, 4'hF);
        rd(0, 2, 0, 32'd12);
        n = 0;
        while (done0[2] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        rd(0, 2, 3, 32'd4);
    endtask

    task automatic test_concurrency;
        wr(0, 1, 0, 32'd1071, 4'hF);
        wr(0, 1, 1, 32'd462, 4'hF);
        wr(0, 3, 0, 32'd0, 4'hF);
        wr(0, 3, 1, 32'd0, 4'hF);
        wr(0, 1, 2, 32'h1, 4'h1);
        wr(0, 3, 2, 32'h1, 4'h1);
        rd(0, 3, 2, 32'h1);
        rd(0, 3, 2, 32'h2);
        vectors++;
        if (done0 !== 4'b1000) begin miscompares++; $display("FAIL concur_done got %b want 1000", done0); end
        rd(0, 1, 2, 32'h1);
        rd(0, 3, 3, 32'd0);
        rd(0, 3, 2, 32'h0);
        rd(0, 1, 3, 32'd21);
        rd(0, 1, 2, 32'h0);
    endtask

    task automatic test_out_of_range;
        int n;
        wr(1, 3, 0, 32'hDEAD_BEEF, 4'hF);
        rd(1, 3, 0, 32'h0);
        rd(1, 0, 0, 32'h0);
        wr(1, 0, 0, 32'h55, 4'hF);
        rd(1, 3, 0, 32'h0);
        wr(1, 3, 2, 32'h1, 4'h1);
        vectors++;
        if (done1 !== 3'b000) begin miscompares++; $display("FAIL oor_done got %b want 000", done1); end
        rd(1, 0, 0, 32'h55);
    endtask

    task automatic test_nonblocking;
        int n;
        wr(1, 1, 0, 32'd15, 4'hF);
        wr(1, 1, 1, 32'd5, 4'hF);
        wr(1, 1, 2, 32'h1, 4'h1);
        req(1, 1'b0, 1, 3, 32'h0, 4'hF, 32'd0, n);
        vectors++;
        if (n != 0) begin miscompares++; $display("FAIL nonblock_stall got %0d want 0", n); end
        n = 0;
        while (done1[1] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        rd(1, 1, 3, 32'd5);
        wr(1, 1, 0, 32'd48, 4'hF);
        wr(1, 1, 1, 32'd18, 4'hF);
        wr(1, 1, 2, 32'h1, 4'h1);
        rd(1, 1, 3, 32'd5);
        rd(1, 1, 2, 32'h1);
    endtask

    task automatic test_reset_mid;
        wr(0, 0, 0, 32'd1071, 4'hF);
        wr(0, 0, 1, 32'd462, 4'hF);
        wr(0, 3, 2, 32'h1, 4'h1);
        wr(0, 0, 2, 32'h1, 4'h1);
        @(negedge clk);
        vectors++;
        if (done0 !== 4'b1000) begin miscompares++; $display("FAIL pre_reset_done got %b want 1000", done0); end
        in_we = 1'b0; in_addr = 32'h0; in_mask = 4'hF; v0 = 1'b1;
        #1;
        vectors++;
        if (yumi0 !== 1'b1) begin miscompares++; $display("FAIL pending_accept got %b want 1", yumi0); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rv0 !== 1'b0 || rd0 !== 32'h0 || done0 !== 4'h0) begin
            miscompares++; $display("FAIL mid_reset got v%b d%h done%b want 0", rv0, rd0, done0);
        end
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(0, 0, 3, 32'h0);
        rd(0, 0, 0, 32'h0);
        rd(0, 3, 2, 32'h0);
        rd(0, 1, 3, 32'h0);
    endtask

    initial begin
        v0 = 1'b0; v1 = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_blocking;
        test_byte_mask;
        test_concurrency;
        test_out_of_range;
        test_nonblocking;
        test_reset_mid;
        repeat (3) @(negedge clk);
        vectors++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain got %0d/%0d want 0/0", sb0.size(), sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
